vga_pattern_gen: RTL



---
 rtl/vga_pat_pkg.sv | 15 +
 rtl/vga_band_decode.sv | 35 +++
 rtl/vga_pattern_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vga_pat_pkg.sv
// Shared constants for the VGA test-pattern generator: pattern codes and
// default active-area dimensions.
package vga_pat_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

endpackage : vga_pat_pkg

// File: rtl/vga_band_decode.sv
// Maps a ramp band index onto r/g/b: red ramp, then green, then blue, then
// saturated white once all three ramps are exhausted.
module vga_band_decode #(
    parameter int CW = 2,
    parameter int NW = 5
) (
    input  logic [NW-1:0] i_n,
    output logic [CW-1:0] o_r,
    output logic [CW-1:0] o_g,
    output logic [CW-1:0] o_b
);

    localparam int S = 1 << CW;

    logic [31:0] w_n;
    assign w_n = 32'(i_n);

    always_comb begin
        o_r = '0;
        o_g = '0;
        o_b = '0;
        if (w_n < 32'(S)) begin
            o_r = CW'(w_n);
        end else if (w_n < 32'(2 * S)) begin
            o_g = CW'(w_n - 32'(S));
        end else if (w_n < 32'(3 * S)) begin
            o_b = CW'(w_n - 32'(2 * S));
        end else begin
            o_r = '1;
            o_g = '1;
            o_b = '1;
        end
    end

endmodule : vga_band_decode

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: four patterns, frame-synchronous mode switching,
// registered colour. Optional border overlay enabled by VGA_PAT_BORDER_EN.
module vga_pattern_gen
    import vga_pat_pkg::*;
#(
    parameter int CW         = 2,
    parameter int HW         = 11,
    parameter int VW         = 10,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int BAND_SHIFT = 5,
    parameter int BAR_SHIFT  = 6,
    parameter int CK_SHIFT   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [HW-1:0] hcount,
    input  logic [VW-1:0] vcount,
    input  logic [1:0]    mode_sel,
    input  logic          mode_req,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic [1:0]    mode_cur,
    output logic [7:0]    frame_cnt
);

    logic [CW-1:0] r_red, r_grn, r_blu;
    logic [1:0]    r_mode_cur;
    logic [1:0]    r_pend_mode;
    logic          r_pend_valid;
    logic [7:0]    r_frame_cnt;

    logic          w_fs;
    logic [1:0]    w_mode;
    logic [CW-1:0] w_red, w_grn, w_blu;
    logic [CW-1:0] w_ramp_r, w_ramp_g, w_ramp_b;
    logic [CW-1:0] w_bar_r, w_bar_g, w_bar_b;
    logic [2:0]    w_bar_c;
    logic          w_ck_t;

    assign w_fs = (hcount == '0) && (vcount == '0);

    // A request landing on the frame-start pixel takes effect on that same pixel.
    always_comb begin
        w_mode = r_mode_cur;
        if (w_fs) begin
            if (mode_req) begin
                w_mode = mode_sel;
            end else if (r_pend_valid) begin
                w_mode = r_pend_mode;
            end
        end
    end

    vga_band_decode #(
        .CW (CW),
        .NW (VW - BAND_SHIFT)
    ) u_band (
        .i_n (vcount[VW-1:BAND_SHIFT]),
        .o_r (w_ramp_r),
        .o_g (w_ramp_g),
        .o_b (w_ramp_b)
    );

    assign w_bar_c = 3'd7 - hcount[BAR_SHIFT+2:BAR_SHIFT];

    for (genvar gi = 0; gi < CW; gi++) begin : g_bar
        assign w_bar_r[gi] = w_bar_c[2];
        assign w_bar_g[gi] = w_bar_c[1];
        assign w_bar_b[gi] = w_bar_c[0];
    end

    // Bit CK_SHIFT of (hcount + frame_cnt): the two operand bits plus the carry
    // out of the low bits, where a + b overflows exactly when a > ~b.
    assign w_ck_t = hcount[CK_SHIFT] ^ r_frame_cnt[CK_SHIFT] ^ vcount[CK_SHIFT]
                  ^ (hcount[CK_SHIFT-1:0] > ~r_frame_cnt[CK_SHIFT-1:0]);

    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        case (w_mode)
            MODE_RAMP: begin
                w_red = w_ramp_r;
                w_grn = w_ramp_g;
                w_blu = w_ramp_b;
            end
            MODE_BARS: begin
                w_red = w_bar_r;
                w_grn = w_bar_g;
                w_blu = w_bar_b;
            end
            MODE_CHECK: begin
                w_red = {CW{w_ck_t}};
                w_grn = {CW{w_ck_t}};
                w_blu = {CW{w_ck_t}};
            end
            MODE_GRAD: begin
                w_red = hcount[CW+5:6];
                w_grn = vcount[CW+5:6];
                w_blu = r_frame_cnt[7:8-CW];
            end
            default: ;
        endcase
`ifdef VGA_PAT_BORDER_EN
        if ((hcount == '0) || (hcount == HW'(H_ACTIVE - 1)) ||
            (vcount == '0) || (vcount == VW'(V_ACTIVE - 1))) begin
            w_red = '1;
            w_grn = '1;
            w_blu = '1;
        end
`endif
        if ((hcount >= HW'(H_ACTIVE)) || (vcount >= VW'(V_ACTIVE))) begin
            w_red = '0;
            w_grn = '0;
            w_blu = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_red        <= '0;
            r_grn        <= '0;
            r_blu        <= '0;
            r_mode_cur   <= MODE_RAMP;
            r_pend_mode  <= MODE_RAMP;
            r_pend_valid <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_red      <= w_red;
            r_grn      <= w_grn;
            r_blu      <= w_blu;
            r_mode_cur <= w_mode;
            if (w_fs) begin
                r_pend_valid <= 1'b0;
                r_frame_cnt  <= r_frame_cnt + 8'd1;
            end else if (mode_req) begin
                r_pend_mode  <= mode_sel;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign r         = r_red;
    assign g         = r_grn;
    assign b         = r_blu;
    assign mode_cur  = r_mode_cur;
    assign frame_cnt = r_frame_cnt;

endmodule : vga_pattern_gen
